// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC (6 iterations, one per clock).
// Drives the vector's Y component to zero while accumulating the rotation angle.
//
// Ports:
//   clk_i                   clock, rising edge
//   rst_i                   asynchronous reset, active low
//   x_i, y_i                signed input vector, N_FRAC+1 bits, sampled with the strobe
//   data_in_valid_strobe_i  one-cycle start request (ignored while busy)
//   mag_o                   unsigned magnitude, N_FRAC+2 bits, held until the next result
//   angle_o                 signed binary angle, 1 LSB = pi/2^N_FRAC, held until next result
//   busy_o                  high whenever the block is not idle
//   data_out_valid_strobe_o one-cycle pulse when mag_o/angle_o update
//
// Optional feature: define CORDIC_GAIN_COMP_EN to scale the magnitude by ~1/1.6468
// (shift-add gain compensation); latency is unchanged.
//
// The arctangent table is scaled for N_FRAC = 7 (pi = 128 LSB).

module cordic_vectoring #(
  parameter int unsigned N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  input  logic                     data_in_valid_strobe_i,
  output logic        [N_FRAC+1:0] mag_o,
  output logic signed [N_FRAC:0]   angle_o,
  output logic                     busy_o,
  output logic                     data_out_valid_strobe_o
);

  localparam int unsigned DW = N_FRAC + 1;
  localparam int unsigned XW = N_FRAC + 3;
  localparam int unsigned MW = N_FRAC + 2;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCalc   = 2'b01,
    StOutput = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [DW-1:0]  z_q, z_d;
  logic [MW-1:0]         mag_q, mag_d;
  logic signed [DW-1:0]  angle_q, angle_d;

  logic signed [XW-1:0]  x_in, y_in;
  logic signed [XW-1:0]  x_sh, y_sh, x_it, y_it, x_fin;
  logic signed [DW-1:0]  z_it, atan;
  logic                  unused_x_msb;

  // Inputs widened by two bits so negating -2^N_FRAC and the CORDIC growth both fit.
  assign x_in = {{2{x_i[DW-1]}}, x_i};
  assign y_in = {{2{y_i[DW-1]}}, y_i};

  always_comb begin
    atan = '0;
    case (cnt_q)
      3'd0:    atan = DW'(32);
      3'd1:    atan = DW'(18);
      3'd2:    atan = DW'(9);
      3'd3:    atan = DW'(5);
      3'd4:    atan = DW'(2);
      3'd5:    atan = DW'(1);
      default: atan = '0;
    endcase
  end

  // One micro-rotation; both updates use the pre-iteration x and y.
  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    if (!y_q[XW-1]) begin
      x_it = x_q + y_sh;
      y_it = y_q - x_sh;
      z_it = z_q + atan;
    end else begin
      x_it = x_q - y_sh;
      y_it = y_q + x_sh;
      z_it = z_q - atan;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  assign x_fin = (x_it >>> 1) + (x_it >>> 3) - (x_it >>> 6) - (x_it >>> 9);
`else
  assign x_fin = x_it;
`endif

  // x stays non-negative, so its sign bit never reaches the magnitude.
  assign unused_x_msb = x_fin[XW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    angle_d = angle_q;
    case (state_q)
      StIdle: begin
        if (data_in_valid_strobe_i) begin
          state_d = StCalc;
          cnt_d   = '0;
          // Left half-plane: rotate by pi first so the iterations converge.
          if (x_i[DW-1]) begin
            x_d = -x_in;
            y_d = -y_in;
            z_d = {1'b1, {N_FRAC{1'b0}}};
          end else begin
            x_d = x_in;
            y_d = y_in;
            z_d = '0;
          end
        end
      end
      StCalc: begin
        x_d   = x_it;
        y_d   = y_it;
        z_d   = z_it;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = StOutput;
          mag_d   = x_fin[MW-1:0];
          angle_d = z_it;
        end
      end
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  assign mag_o                   = mag_q;
  assign angle_o                 = angle_q;
  assign busy_o                  = (state_q != StIdle);
  assign data_out_valid_strobe_o = (state_q == StOutput);

endmodule
